muldiv_seq: RTL and testbench

//  Iterative RV32M multiply/divide sequencer alongside the execute-stage ALU.

---
 rtl/muldiv_seq.sv | 134 +++++++++++++
 tb/tb_muldiv_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, stalling E until done.
module muldiv_seq #(
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned CNT_W   = $clog2(D_WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_e,
    input  logic               flush_e,
    input  logic [2:0]         funct3_e,
    input  logic [D_WIDTH-1:0] src_a_e,
    input  logic [D_WIDTH-1:0] src_b_e,
    output logic               stall_e,
    output logic               md_valid_e,
    output logic [D_WIDTH-1:0] md_result_e,
    output logic               busy
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       count_q;
    logic [2:0]             op_q;
    logic                   neg_res_q, neg_rem_q;
    logic [D_WIDTH-1:0]     opnd_q;
    logic [2*D_WIDTH-1:0]   acc_q;
    logic [D_WIDTH-1:0]     result_q;

    logic                   start_ok, is_div, a_signed, b_signed, a_neg, b_neg;
    logic                   div_zero, div_ovf, special, last_iter;
    logic [D_WIDTH-1:0]     a_mag, b_mag, special_res;
    logic [D_WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [2*D_WIDTH-1:0]   mul_next, div_next, acc_next, prod;
    logic [D_WIDTH-1:0]     quo, rem, final_res;

    // Operand capture and special-case detection in the start cycle.
    always_comb begin
        start_ok    = start_e & ~flush_e;
        is_div      = funct3_e[2];
        a_signed    = (funct3_e == 3'b001) | (funct3_e == 3'b010) |
                      (funct3_e == 3'b100) | (funct3_e == 3'b110);
        b_signed    = (funct3_e == 3'b001) | (funct3_e == 3'b100) | (funct3_e == 3'b110);
        a_neg       = a_signed & src_a_e[D_WIDTH-1];
        b_neg       = b_signed & src_b_e[D_WIDTH-1];
        a_mag       = a_neg ? -src_a_e : src_a_e;
        b_mag       = b_neg ? -src_b_e : src_b_e;
        div_zero    = is_div & (src_b_e == '0);
        div_ovf     = is_div & ~funct3_e[0] & (src_b_e == '1) &
                      (src_a_e == {1'b1, {(D_WIDTH-1){1'b0}}});
        special     = div_zero | div_ovf;
        if (div_zero) begin
            special_res = funct3_e[1] ? src_a_e : '1;
        end else begin
            special_res = funct3_e[1] ? '0 : src_a_e;
        end
    end

    // One iteration; acc_q holds {hi, lo} = {product hi / remainder, multiplier / quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*D_WIDTH-1:D_WIDTH]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(D_WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc_q[D_WIDTH-1:1]};
        div_shift = acc_q[2*D_WIDTH-1:D_WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        if (div_diff[D_WIDTH]) begin
            div_next = {div_shift[D_WIDTH-1:0], acc_q[D_WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[D_WIDTH-1:0], acc_q[D_WIDTH-2:0], 1'b1};
        end
        acc_next  = op_q[2] ? div_next : mul_next;
        prod      = neg_res_q ? -acc_next : acc_next;
        quo       = acc_next[D_WIDTH-1:0];
        rem       = acc_next[2*D_WIDTH-1:D_WIDTH];
        if (op_q[2]) begin
            if (op_q[1]) final_res = neg_rem_q ? -rem : rem;
            else         final_res = neg_res_q ? -quo : quo;
        end else begin
            final_res = (op_q[1:0] == 2'b00) ? prod[D_WIDTH-1:0] : prod[2*D_WIDTH-1:D_WIDTH];
        end
        last_iter = (count_q == CNT_W'(D_WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_ok) state_d = special ? StDone : StBusy;
            StBusy: begin
                if (flush_e)        state_d = StIdle;
                else if (last_iter) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall_e    = ((state_q == StIdle) & start_ok) | (state_q == StBusy);
        md_valid_e = (state_q == StDone);
        busy       = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            result_q  <= '0;
        end else if ((state_q == StIdle) && start_ok) begin
            count_q   <= '0;
            op_q      <= funct3_e;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            opnd_q    <= is_div ? b_mag : a_mag;
            acc_q     <= {{D_WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
            if (special) result_q <= special_res;
        end else if ((state_q == StBusy) && !flush_e) begin
            count_q <= count_q + CNT_W'(1);
            acc_q   <= acc_next;
            if (last_iter) result_q <= final_res;
        end
    end

    assign md_result_e = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic results, latency, special cases,
// flush, mid-op reset and back-to-back issue.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst, start_e, flush_e;
    logic [2:0]  funct3_e;
    logic [31:0] src_a_e, src_b_e;
    logic        stall_e, md_valid_e, busy;
    logic [31:0] md_result_e;

    int vectors = 0;
    int errors  = 0;

    muldiv_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start_e     (start_e),
        .flush_e     (flush_e),
        .funct3_e    (funct3_e),
        .src_a_e     (src_a_e),
        .src_b_e     (src_b_e),
        .stall_e     (stall_e),
        .md_valid_e  (md_valid_e),
        .md_result_e (md_result_e),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Drives one op from just after a rising edge, holding start_e through DONE
    // and scrambling the operands after the start cycle. Reports the observed
    // stall count, the cycle md_valid_e rose (-1 if never) and the result.
    task automatic issue_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            output int stalls, output int vcyc, output logic [31:0] res);
        stalls   = 0;
        vcyc     = -1;
        res      = 'x;
        start_e  = 1'b1;
        funct3_e = f3;
        src_a_e  = a;
        src_b_e  = b;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (stall_e) stalls++;
            if (md_valid_e) begin
                vcyc = c;
                res  = md_result_e;
            end
            @(posedge clk);
            #1;
            src_a_e = $urandom;
            src_b_e = $urandom;
            if (vcyc >= 0) break;
        end
        start_e = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors += 4;
        if (stall_e !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_e); end
        if (md_valid_e !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", md_valid_e); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (md_result_e !== 32'h0) begin
            errors++; $display("FAIL reset_result got %h want 0", md_result_e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_normal_ops();
        logic [2:0]  f [8];
        logic [31:0] a [8];
        logic [31:0] b [8];
        logic [31:0] e [8];
        int          st, vc;
        logic [31:0] r;
        f = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b101, 3'b111, 3'b100, 3'b110};
        a = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        b = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd7, 32'd2, 32'd2};
        e = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
              32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        for (int i = 0; i < 8; i++) begin
            issue_op(f[i], a[i], b[i], st, vc, r);
            vectors += 3;
            if (r !== e[i]) begin
                errors++; $display("FAIL op%0d_result f3=%b got %h want %h", i, f[i], r, e[i]);
            end
            if (st != 33) begin errors++; $display("FAIL op%0d_stalls got %0d want 33", i, st); end
            if (vc != 33) begin errors++; $display("FAIL op%0d_valid_cycle got %0d want 33", i, vc); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  f [5];
        logic [31:0] a [5];
        logic [31:0] b [5];
        logic [31:0] e [5];
        int          st, vc;
        logic [31:0] r;
        f = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b101};
        a = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9};
        b = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        e = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            issue_op(f[i], a[i], b[i], st, vc, r);
            vectors += 3;
            if (r !== e[i]) begin
                errors++; $display("FAIL sp%0d_result f3=%b got %h want %h", i, f[i], r, e[i]);
            end
            if (st != 1) begin errors++; $display("FAIL sp%0d_stalls got %0d want 1", i, st); end
            if (vc != 1) begin errors++; $display("FAIL sp%0d_valid_cycle got %0d want 1", i, vc); end
        end
    endtask

    task automatic test_flush();
        logic        seen_valid = 1'b0;
        int          st, vc;
        logic [31:0] r;
        start_e  = 1'b1;
        funct3_e = 3'b000;
        src_a_e  = 32'd3;
        src_b_e  = 32'd5;
        // Eleven edges: start cycle, then BUSY counts 0..10.
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            seen_valid |= md_valid_e;
            @(posedge clk);
            #1;
        end
        flush_e = 1'b1;
        @(negedge clk);
        seen_valid |= md_valid_e;
        vectors++;
        if (stall_e !== 1'b1) begin errors++; $display("FAIL flush_busy_stall got %b want 1", stall_e); end
        @(posedge clk);
        #1;
        flush_e = 1'b0;
        start_e = 1'b0;
        @(negedge clk);
        seen_valid |= md_valid_e;
        vectors += 3;
        if (stall_e !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall_e); end
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
        if (seen_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got 1 want 0"); end
        @(posedge clk);
        #1;
        issue_op(3'b101, 32'd100, 32'd7, st, vc, r);
        vectors += 2;
        if (r !== 32'd14) begin errors++; $display("FAIL post_flush_result got %h want e", r); end
        if (vc != 33) begin errors++; $display("FAIL post_flush_cycle got %0d want 33", vc); end
    endtask

    task automatic test_flush_masks_start();
        start_e  = 1'b1;
        flush_e  = 1'b1;
        funct3_e = 3'b000;
        @(negedge clk);
        vectors++;
        if (stall_e !== 1'b0) begin errors++; $display("FAIL flush_mask_stall got %b want 0", stall_e); end
        @(posedge clk);
        #1;
        start_e = 1'b0;
        flush_e = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_mask_busy got %b want 0", busy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic seen_valid = 1'b0;
        start_e  = 1'b1;
        funct3_e = 3'b011;
        src_a_e  = 32'hFFFF_FFFF;
        src_b_e  = 32'hFFFF_FFFF;
        for (int c = 0; c < 21; c++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        start_e = 1'b0;
        @(negedge clk);
        vectors += 4;
        if (md_result_e !== 32'h0) begin
            errors++; $display("FAIL rst_mid_result got %h want 0", md_result_e);
        end
        if (stall_e !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b want 0", stall_e); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            seen_valid |= md_valid_e;
        end
        if (seen_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got 1 want 0"); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int          st, vc;
        logic [31:0] r;
        issue_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, vc, r);
        vectors += 2;
        if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_first got %h want fffffffe", r); end
        if (vc != 33) begin errors++; $display("FAIL b2b_first_cycle got %0d want 33", vc); end
        issue_op(3'b100, 32'hFFFF_FFF9, 32'd2, st, vc, r);
        vectors += 3;
        if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL b2b_second got %h want fffffffd", r); end
        if (vc != 33) begin errors++; $display("FAIL b2b_second_cycle got %0d want 33", vc); end
        if (st != 33) begin errors++; $display("FAIL b2b_second_stalls got %0d want 33", st); end
    endtask

    initial begin
        rst      = 1'b1;
        start_e  = 1'b0;
        flush_e  = 1'b0;
        funct3_e = 3'b000;
        src_a_e  = '0;
        src_b_e  = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_normal_ops();
        test_special();
        test_flush();
        test_flush_masks_start();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
